// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment page controller: segment codes,
// sequencer state encoding and page-select width.
// Latency: n/a (package). Backpressure: n/a.
package seg7_pkg;

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_e;

  // Two views (low and high halves of the snapshots) need one select bit.
  localparam int PAGE_W = 1;

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to seven-segment decoder (active-low, {a,b,c,d,e,f,g}).
// Latency: purely combinational. Backpressure: none.
// Ports: nib_i - 4-bit hex digit; seg_o - 7-bit segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_page_ctrl.sv
// Six-digit display sequencer: snapshots PC_val/WD_val on sample_en (unless
// frozen) and pages between two views with a blanking gap on every change.
// Latency: strobe to HEX = 2 cycles; page advance to blank HEX = 1 cycle.
// Backpressure: none; page_btn edges arriving during blanking are dropped.
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   PC_val, WD_val          - 32-bit debug buses from the core
//   sample_en, freeze       - capture strobe and capture inhibit (level)
//   auto_mode, page_btn     - timed paging enable, manual advance button
//   HEX5..HEX0              - registered active-low segment patterns
//   page, blanking          - current page and blank-interval flag
module seg7_page_ctrl
  import seg7_pkg::*;
#(
  parameter int DWELL     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       PC_val,
  input  logic [31:0]       WD_val,
  input  logic              sample_en,
  input  logic              freeze,
  input  logic              auto_mode,
  input  logic              page_btn,
  output logic [6:0]        HEX5,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX0,
  output logic [PAGE_W-1:0] page,
  output logic              blanking
);

  // Width guards keep the counters at least one bit wide for degenerate values.
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  logic [31:0]       pc_q;
  logic [31:0]       wd_q;
  logic [PAGE_W-1:0] page_q;
  state_e            state_q;
  logic [DW-1:0]     dwell_q;
  logic [BW-1:0]     blank_q;
  logic              page_btn_q;
  logic              blanking_q;
  logic [5:0][6:0]   hex_q;

  logic [5:0][3:0]   nib;
  logic [5:0][6:0]   seg;
  logic              btn_rise;
  logic              dwell_done;
  logic              advance_d;

  // Only the low 16 PC bits are ever displayed; the rest are kept in the
  // snapshot so a debugger view of pc_q matches the core.
  logic unused_pc_hi;
  assign unused_pc_hi = ^pc_q[31:16];

  // Digit 5 is the MSB slice, so each view is one contiguous concatenation.
  always_comb begin
    nib = {pc_q[7:0], wd_q[15:0]};
    if (page_q != '0) begin
      nib = {pc_q[15:8], wd_q[31:16]};
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_dec
    hex_to_seg7 u_dec (
      .nib_i (nib[gi]),
      .seg_o (seg[gi])
    );
  end

  assign btn_rise   = page_btn & ~page_btn_q;
  assign dwell_done = auto_mode && (dwell_q == DWELL_LAST);
  // Expiry and button in the same cycle collapse into one advance.
  assign advance_d  = (state_q == SHOW) && (dwell_done || btn_rise);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= '0;
      wd_q       <= '0;
      page_q     <= '0;
      state_q    <= SHOW;
      dwell_q    <= '0;
      blank_q    <= '0;
      page_btn_q <= 1'b0;
      blanking_q <= 1'b0;
      hex_q      <= {6{SEG_0}};
    end else begin
      page_btn_q <= page_btn;

      if (sample_en && !freeze) begin
        pc_q <= PC_val;
        wd_q <= WD_val;
      end

      // Output stage follows the state one cycle behind, so HEX blanks
      // starting the cycle after the page flag changes.
      hex_q <= (state_q == BLANK) ? {6{SEG_BLANK}} : seg;

      case (state_q)
        SHOW: begin
          if (advance_d) begin
            page_q     <= ~page_q;
            dwell_q    <= '0;
            blank_q    <= '0;
            state_q    <= BLANK;
            blanking_q <= 1'b1;
          end else if (auto_mode) begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        BLANK: begin
          if (blank_q == BLANK_LAST) begin
            blank_q    <= '0;
            state_q    <= SHOW;
            blanking_q <= 1'b0;
          end else begin
            blank_q <= blank_q + 1'b1;
          end
        end
        default: begin
          state_q    <= SHOW;
          blanking_q <= 1'b0;
        end
      endcase
    end
  end

  assign HEX5     = hex_q[5];
  assign HEX4     = hex_q[4];
  assign HEX3     = hex_q[3];
  assign HEX2     = hex_q[2];
  assign HEX1     = hex_q[1];
  assign HEX0     = hex_q[0];
  assign page     = page_q;
  assign blanking = blanking_q;

endmodule

// File: tb/tb_seg7_page_ctrl.sv
// Directed bench for seg7_page_ctrl: a vector table of per-cycle inputs and
// expected outputs, followed by hand-written auto-mode sequences.
// Expected segment patterns come from the bench's own nibble table.
module tb_seg7_page_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC_val = '0;
  logic [31:0] WD_val = '0;
  logic        sample_en = 1'b0;
  logic        freeze = 1'b0;
  logic        auto_mode = 1'b0;
  logic        page_btn = 1'b0;
  logic [6:0]  HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  logic [0:0]  page;
  logic        blanking;

  int n_vec = 0;
  int n_err = 0;

  seg7_page_ctrl #(.DWELL(16), .BLANK_CYC(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .PC_val    (PC_val),
    .WD_val    (WD_val),
    .sample_en (sample_en),
    .freeze    (freeze),
    .auto_mode (auto_mode),
    .page_btn  (page_btn),
    .HEX5      (HEX5),
    .HEX4      (HEX4),
    .HEX3      (HEX3),
    .HEX2      (HEX2),
    .HEX1      (HEX1),
    .HEX0      (HEX0),
    .page      (page),
    .blanking  (blanking)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, se, frz, au, btn;
    logic [31:0] pc, wd;
    logic [41:0] hex;
    logic        pg, bl;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b0000001;  4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;  4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;  4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;  4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0001100;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;  4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;  default: seg = 7'b0111000;
    endcase
  endfunction

  // Six digits, HEX5 first in the nibble string.
  function automatic logic [41:0] h6(input logic [23:0] n);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*7 +: 7] = seg(n[i*4 +: 4]);
    return r;
  endfunction

  task automatic add(input logic rst, se, frz, au, btn,
                     input logic [31:0] pc, wd,
                     input logic [41:0] hex, input logic pg, bl);
    vec_t v;
    v.rst = rst; v.se = se; v.frz = frz; v.au = au; v.btn = btn;
    v.pc = pc; v.wd = wd; v.hex = hex; v.pg = pg; v.bl = bl;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic chk_hex,
                       input logic [41:0] exp_hex, input logic exp_pg, exp_bl);
    logic [41:0] got_hex;
    got_hex = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    n_vec++;
    if ((chk_hex && got_hex !== exp_hex) || page !== exp_pg || blanking !== exp_bl) begin
      n_err++;
      $display("FAIL %s: got hex=%h page=%b blanking=%b, want hex=%h page=%b blanking=%b",
               name, got_hex, page, blanking, exp_hex, exp_pg, exp_bl);
    end
  endtask

  logic [41:0] Z, P0A, P1A, BL, P0B, P1B;

  initial begin
    Z   = h6(24'h000000);
    P0A = h6(24'h2CCDEF);
    P1A = h6(24'h1A89AB);
    P0B = h6(24'h2C1234);
    P1B = h6(24'h1A0000);
    BL  = {6{7'b1111111}};

    //   rst se frz au btn  PC_val        WD_val        hex  pg bl
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         Z,   0, 0); // reset
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         Z,   0, 0); // idle
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         Z,   0, 0);
    add(0, 1, 0, 0, 0, 32'h0000_1A2C, 32'h89AB_CDEF, Z,   0, 0); // capture
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         P0A, 0, 0); // +2 cycles
    add(0, 0, 0, 0, 1, 32'h0,         32'h0,         P0A, 1, 1); // button edge
    add(0, 0, 0, 0, 1, 32'h0,         32'h0,         BL,  1, 1);
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         BL,  1, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         P1A, 1, 0); // page 1
    add(0, 0, 0, 0, 1, 32'h0,         32'h0,         P1A, 0, 1); // back to 0
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         BL,  0, 1);
    add(0, 0, 0, 0, 1, 32'h0,         32'h0,         BL,  0, 0); // edge in BLANK
    add(0, 0, 0, 0, 1, 32'h0,         32'h0,         P0A, 0, 0); // ignored
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         P0A, 0, 0);
    add(0, 1, 1, 0, 0, 32'h0,         32'h0000_1234, P0A, 0, 0); // frozen
    add(0, 0, 1, 0, 0, 32'h0,         32'h0,         P0A, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         P0A, 0, 0);
    add(0, 1, 0, 0, 0, 32'h0000_1A2C, 32'h0000_1234, P0A, 0, 0); // unfrozen
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         P0B, 0, 0);
    add(0, 0, 1, 0, 1, 32'h0,         32'h0,         P0B, 1, 1); // paging frozen
    add(0, 0, 1, 0, 0, 32'h0,         32'h0,         BL,  1, 1);
    add(0, 0, 1, 0, 0, 32'h0,         32'h0,         BL,  1, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         P1B, 1, 0);
    add(0, 0, 0, 0, 1, 32'h0,         32'h0,         P1B, 0, 1); // enter BLANK
    add(1, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, Z,   0, 0); // reset mid-BLANK
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         Z,   0, 0); // no capture

    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst;
      sample_en = vecs[i].se;
      freeze    = vecs[i].frz;
      auto_mode = vecs[i].au;
      page_btn  = vecs[i].btn;
      PC_val    = vecs[i].pc;
      WD_val    = vecs[i].wd;
      tick();
      check($sformatf("vec%0d", i), 1'b1, vecs[i].hex, vecs[i].pg, vecs[i].bl);
    end

    // Auto mode: reset at edge k=0, then auto on; first expiry at k=16.
    reset = 1'b1; sample_en = 1'b0; freeze = 1'b0; page_btn = 1'b0;
    tick();
    reset = 1'b0; auto_mode = 1'b1;
    for (int k = 1; k <= 15; k++) tick();
    check("auto_k15", 1'b1, Z, 1'b0, 1'b0);
    tick();                                       // k=16
    check("auto_expire1", 1'b0, Z, 1'b1, 1'b1);
    tick();                                       // k=17
    check("auto_blank", 1'b1, BL, 1'b1, 1'b1);
    tick();                                       // k=18
    check("auto_show", 1'b1, BL, 1'b1, 1'b0);
    for (int k = 19; k <= 33; k++) tick();
    check("auto_k33", 1'b1, Z, 1'b1, 1'b0);
    page_btn = 1'b1;
    tick();                                       // k=34: expiry + button
    check("auto_btn_same", 1'b0, Z, 1'b0, 1'b1);
    page_btn = 1'b0;
    tick();                                       // k=35
    check("auto_k35", 1'b1, BL, 1'b0, 1'b1);
    page_btn = 1'b1;
    tick();                                       // k=36: edge during BLANK
    check("auto_btn_blank", 1'b1, BL, 1'b0, 1'b0);
    page_btn = 1'b0;
    tick();                                       // k=37
    check("auto_k37", 1'b1, Z, 1'b0, 1'b0);
    for (int k = 38; k <= 51; k++) tick();
    check("auto_k51", 1'b0, Z, 1'b0, 1'b0);
    tick();                                       // k=52
    check("auto_expire3", 1'b0, Z, 1'b1, 1'b1);

    // Back in SHOW at k=54; run 5 counts, pause 10 cycles, resume.
    for (int k = 53; k <= 59; k++) tick();
    auto_mode = 1'b0;
    for (int k = 60; k <= 69; k++) tick();
    check("auto_paused", 1'b1, Z, 1'b1, 1'b0);
    auto_mode = 1'b1;
    for (int k = 70; k <= 79; k++) tick();
    check("auto_resume_k79", 1'b1, Z, 1'b1, 1'b0);
    tick();                                       // k=80
    check("auto_resume_k80", 1'b0, Z, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_page_ctrl.md
# seg7_page_ctrl

Display sequencer that drives the six seven-segment digits (HEX5..HEX0) from the processor's PC_val and WD_val debug buses. It captures samples on a strobe, can freeze the captured values, and pages through two views so that 16 PC bits and all 32 WD bits can be shown on six digits. Each page change inserts a short blanking interval. It sits between the mips core outputs and the board's HEX pins, replacing ad-hoc combinational decoding.

## Interface
- DWELL, 16: cycles a page is shown in auto mode before advancing (≥2; board builds use 50_000_000)
- BLANK_CYC, 2: cycles all digits are blanked after each page change (≥1)
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- PC_val  in  32  program counter from the core
- WD_val  in  32  register-file write data from the core
- sample_en  in  1  capture PC_val/WD_val this cycle
- freeze  in  1  level; while 1, captures are suppressed
- auto_mode  in  1  level; 1 = pages advance every DWELL cycles
- page_btn  in  1  synchronous level input; its rising edge requests a manual page advance
- HEX5..HEX0  out  7 each  segment patterns, active-low, bit order {a,b,c,d,e,f,g}
- page  out  1  currently selected page
- blanking  out  1  1 while in the BLANK state

## Operation
- Snapshot registers pc_q and wd_q load PC_val and WD_val when sample_en=1 and freeze=0. Otherwise they hold.
- Page 0 shows:
  - HEX5:HEX4 = pc_q[7:4], pc_q[3:0]
  - HEX3..HEX0 = wd_q[15:12], [11:8], [7:4], [3:0]
- Page 1 shows:
  - HEX5:HEX4 = pc_q[15:12], pc_q[11:8]
  - HEX3..HEX0 = wd_q[31:28] down to wd_q[19:16]
- Nibble-to-segment codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, B=1100000
  - C=0110001, D=1000010, E=0110000, F=0111000
  - blank = 1111111
- States:
  - SHOW: digits decode the current page. The dwell counter increments every cycle when auto_mode=1 and holds when auto_mode=0.
    - An advance event is either (auto_mode=1 and counter = DWELL−1) or a page_btn rising edge.
    - On an advance event: page toggles, counter clears, next state is BLANK.
  - BLANK: all digits = 1111111. The blank counter counts BLANK_CYC cycles, then the block returns to SHOW with the counter cleared.
- Edge detection: page_btn_q is a registered copy of page_btn; rising edge = page_btn & ~page_btn_q.
- Simultaneous auto expiry and button edge in the same cycle: exactly one page advance.
- A button edge during BLANK is ignored (not queued).
- The dwell counter does not run during BLANK.
- Clearing auto_mode mid-dwell holds the counter value. Setting auto_mode again resumes from that value.
- freeze does not stop paging; it only stops capture.

## Timing
- All outputs are registered.
- Capture latency: sample_en at edge n → pc_q/wd_q updated at edge n → HEX reflects the new value after edge n+1 (2 cycles from strobe).
- Page change: the advance condition is true at edge n → page and blanking change at edge n, and HEX outputs are blank after edge n+1.
  - Blanking lasts exactly BLANK_CYC cycles on HEX.
  - The new page appears after edge n+1+BLANK_CYC.
- Auto mode: page period = DWELL + BLANK_CYC cycles.
- Reset values (reset=1 on any edge):
  - pc_q=0, wd_q=0, page=0, blanking=0
  - state=SHOW, both counters=0, page_btn_q=0
  - HEX5..HEX0 = 0000001 (digit "0")
- reset mid-BLANK or mid-dwell: immediately returns to the reset state with no partial page change. reset overrides sample_en.

## Structure
- Shared package seg7_pkg holds:
  - the 16 nibble segment constants plus SEG_BLANK
  - the state enum {SHOW, BLANK}
  - the page width constant
- One sub-module, hex_to_seg7: purely combinational, 4-bit nibble in → 7-bit active-low pattern out. Instantiated six times, with the registered output stage in the parent.
- Counter widths are $clog2 of DWELL and BLANK_CYC.

## Test plan
- Reset then idle, auto_mode=0:
  - all HEX = 0000001, page=0, blanking=0 indefinitely.
- Capture and decode, page 0: PC_val=32'h0000_1A2C, WD_val=32'h89AB_CDEF, sample_en pulsed.
  - 2 cycles later HEX5..HEX0 = 2,C,C,D,E,F (0010010, 0110001, 0110001, 1000010, 0110000, 0111000).
- Manual page: page_btn rising edge.
  - blanking=1 and HEX=1111111 for 2 cycles.
  - Then page 1 shows 1,A,8,9,A,B.
- Auto mode, DWELL=16, BLANK_CYC=2:
  - page toggles every 18 cycles.
  - A button edge in the same cycle as expiry gives a single toggle.
  - A button edge during BLANK causes no extra toggle.
- Freeze: freeze=1, then sample_en with WD_val=32'h0000_1234.
  - Display keeps the old snapshot.
  - After freeze=0, the next sample_en shows 1,2,3,4 on HEX3..0.
- Reset mid-BLANK:
  - the next cycle shows page=0, blanking=0, all HEX = 0000001.
